// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: VGA pixel fetch has priority over
// the full-framebuffer clear engine, which has priority over the requester write port.
module vga_fb_arbiter #(
    parameter bit WRITE_ANYTIME = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcounter,
    input  logic [9:0]  vcounter,
    input  logic        lower_blank,
    output logic [7:0]  pixels,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_wdata,
    output logic        sram_we,
    input  logic [7:0]  sram_rdata,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    input  logic        clr_req,
    output logic        clr_busy
);

    localparam int unsigned H_TOTAL        = 800;
    localparam int unsigned H_VIS          = 640;
    localparam int unsigned V_TOTAL        = 525;
    localparam int unsigned V_VIS          = 480;
    localparam int unsigned BYTES_PER_LINE = 80;
    localparam int unsigned FB_BYTES       = BYTES_PER_LINE * V_VIS;
    localparam int unsigned FETCH_LEAD     = 3;
    localparam int unsigned FETCH_PHASE    = 5;
    localparam int unsigned LOAD_PHASE     = 7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]  pixels_q, pixels_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        busy_q;
    logic        fetch_pend_q, fetch_pend_d;

    logic [10:0] h_ahead;
    logic [10:0] tgt_h;
    logic [9:0]  tgt_v;
    logic        fetch_slot;
    logic        fetch_valid;
    logic [15:0] fetch_addr;
    logic        slot_open;

    // Group fetched in this slot is the one starting three pixels ahead, possibly on the next line.
    always_comb begin
        h_ahead = hcounter + 11'(FETCH_LEAD);
        tgt_h   = h_ahead;
        tgt_v   = vcounter;
        if (h_ahead >= 11'(H_TOTAL)) begin
            tgt_h = h_ahead - 11'(H_TOTAL);
            tgt_v = (vcounter == 10'(V_TOTAL - 1)) ? 10'd0 : vcounter + 10'd1;
        end
        fetch_slot  = (hcounter[2:0] == 3'(FETCH_PHASE));
        fetch_valid = fetch_slot && (tgt_h < 11'(H_VIS)) && (tgt_v < 10'(V_VIS));
        fetch_addr  = 16'(tgt_v) * 16'(BYTES_PER_LINE) + 16'(tgt_h[10:3]);
        slot_open   = !fetch_valid && (lower_blank || WRITE_ANYTIME);
    end

    // Slot arbitration and clear FSM next-state.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        pixels_d     = pixels_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        ack_d        = 1'b0;
        fetch_pend_d = fetch_pend_q;

        if (fetch_slot) begin
            fetch_pend_d = fetch_valid;
        end
        if (fetch_valid) begin
            addr_d = fetch_addr;
        end
        // Blank groups load zero so nothing stale shows outside the active area.
        if (hcounter[2:0] == 3'(LOAD_PHASE)) begin
            pixels_d     = fetch_pend_q ? sram_rdata : 8'h00;
            fetch_pend_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (wr_req && slot_open) begin
                    addr_d  = wr_addr;
                    wdata_d = wr_data;
                    we_d    = (wr_addr < 16'(FB_BYTES));
                    ack_d   = 1'b1;
                end
            end
            S_CLEAR: begin
                if (slot_open) begin
                    addr_d    = clr_cnt_q;
                    wdata_d   = 8'h00;
                    we_d      = 1'b1;
                    clr_cnt_d = clr_cnt_q + 16'd1;
                    if (clr_cnt_q == 16'(FB_BYTES - 1)) begin
                        state_d   = S_IDLE;
                        clr_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            pixels_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            fetch_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            pixels_q     <= pixels_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            ack_q        <= ack_d;
            busy_q       <= (state_d == S_CLEAR);
            fetch_pend_q <= fetch_pend_d;
        end
    end

    assign pixels     = pixels_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_we    = we_q;
    assign wr_ack     = ack_q;
    assign clr_busy   = busy_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized self-checking bench for vga_fb_arbiter: behavioural SRAM, framebuffer
// reference array and expectations computed from the VGA timing rules.
module tb_vga_fb_arbiter;

    localparam int FB_BYTES = 38400;

    logic        clk;
    logic        reset;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    wire         lower_blank = (vcnt > 10'd479);

    logic [7:0]  pixels,   pixels_a;
    logic [15:0] sram_addr, sram_addr_a;
    logic [7:0]  sram_wdata, sram_wdata_a;
    logic        sram_we,  sram_we_a;
    logic [7:0]  sram_rdata, sram_rdata_a;
    logic        wr_req,   wr_req_a;
    logic [15:0] wr_addr,  wr_addr_a;
    logic [7:0]  wr_data,  wr_data_a;
    logic        wr_ack,   wr_ack_a;
    logic        clr_req,  clr_req_a;
    logic        clr_busy, clr_busy_a;

    int n_tests = 0;
    int n_fail  = 0;
    int run_len = 0;
    int unsigned salt = 0;

    logic [7:0] mem     [0:FB_BYTES-1];
    bit         wr_seen [0:FB_BYTES-1];
    logic [7:0] exp_fb  [0:FB_BYTES-1];

    vga_fb_arbiter #(.WRITE_ANYTIME(1'b0)) u_dut (
        .clk(clk), .reset(reset), .hcounter(hcnt), .vcounter(vcnt),
        .lower_blank(lower_blank), .pixels(pixels), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_rdata(sram_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    vga_fb_arbiter #(.WRITE_ANYTIME(1'b1)) u_dut_any (
        .clk(clk), .reset(reset), .hcounter(hcnt), .vcounter(vcnt),
        .lower_blank(lower_blank), .pixels(pixels_a), .sram_addr(sram_addr_a),
        .sram_wdata(sram_wdata_a), .sram_we(sram_we_a), .sram_rdata(sram_rdata_a),
        .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ack(wr_ack_a),
        .clr_req(clr_req_a), .clr_busy(clr_busy_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 0) return 8'hA5;
        return 8'((i * 37) ^ (i >> 7)) ^ 8'(salt);
    endfunction

    function automatic logic [7:0] fb_val(input int i);
        return wr_seen[i] ? mem[i] : init_byte(i);
    endfunction

    // Synchronous SRAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (sram_we && sram_addr < 16'(FB_BYTES)) begin
            mem[sram_addr]     <= sram_wdata;
            wr_seen[sram_addr] <= 1'b1;
        end
        sram_rdata <= (sram_addr < 16'(FB_BYTES)) ? fb_val(int'(sram_addr)) : 8'h00;
    end

    always @(posedge clk) sram_rdata_a <= sram_addr_a[7:0] ^ 8'h3C;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d)", tag, got, exp, hcnt, vcnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input bit blank_loop);
        if (hcnt == 11'd799) begin
            hcnt = '0;
            if (blank_loop && vcnt == 10'd523) vcnt = 10'd480;
            else if (vcnt == 10'd524) vcnt = '0;
            else vcnt = vcnt + 10'd1;
        end else begin
            hcnt = hcnt + 11'd1;
        end
        run_len++;
    endtask

    task automatic jump(input int v, input int h);
        vcnt    = 10'(v);
        hcnt    = 11'(h);
        run_len = 0;
    endtask

    task automatic fb_compare(input string tag);
        int bad = 0;
        for (int i = 0; i < FB_BYTES; i++)
            if (fb_val(i) !== exp_fb[i]) bad++;
        chk(tag, 32'(bad), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (h=%0d v=%0d)", hcnt, vcnt);
        $fatal(1);
    end

    initial begin
        int ph, pv, th, tv, idx, nwr, seq_err, stray, vis_acks, exp_pix;
        bit got, done, repulsed, prev_busy;
        logic [15:0] a;
        logic [7:0]  d;

        salt = $urandom;
        for (int i = 0; i < FB_BYTES; i++) exp_fb[i] = init_byte(i);

        reset = 1'b1; clr_req = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        clr_req_a = 1'b0; wr_req_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        jump(500, 0);
        repeat (3) tick();
        chk("rst_pixels", 32'(pixels), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_wdata", 32'(sram_wdata), 0);
        chk("rst_we", 32'(sram_we), 0);
        chk("rst_ack", 32'(wr_ack), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_busy_any", 32'(clr_busy_a), 0);
        reset = 1'b0;

        // Display path across the frame wrap, plus a write racing a fetch on the anytime instance.
        jump(524, 700);
        while (!(vcnt == 10'd3 && hcnt == 11'd0)) begin
            if (vcnt == 10'd1 && hcnt == 11'd101) begin
                wr_req_a = 1'b1; wr_addr_a = 16'd12345; wr_data_a = 8'h5A;
            end
            ph = int'(hcnt); pv = int'(vcnt);
            tick();
            if (ph % 8 == 5) begin
                th = ph + 3; tv = pv;
                if (th >= 800) begin th -= 800; tv = (pv == 524) ? 0 : pv + 1; end
                if (th < 640 && tv < 480) chk("fetch_addr", 32'(sram_addr), 32'(tv * 80 + th / 8));
                chk("fetch_we", 32'(sram_we), 0);
            end
            if (pv == 1 && ph == 101) begin
                chk("any_fetch_addr", 32'(sram_addr_a), 93);
                chk("any_fetch_ack", 32'(wr_ack_a), 0);
            end
            if (pv == 1 && ph == 102) begin
                chk("any_ack", 32'(wr_ack_a), 1);
                chk("any_we", 32'(sram_we_a), 1);
                chk("any_addr", 32'(sram_addr_a), 12345);
                chk("any_wdata", 32'(sram_wdata_a), 32'h5A);
                wr_req_a = 1'b0;
            end
            if (pv == 1 && ph == 103) chk("any_pixels", 32'(pixels_a), 32'h61);
            adv(1'b0);
            if (run_len >= 16) begin
                idx = int'(vcnt) * 80 + int'(hcnt) / 8;
                exp_pix = (hcnt < 11'd640 && vcnt < 10'd480) ? int'(exp_fb[idx]) : 0;
                chk("pixels", 32'(pixels), 32'(exp_pix));
            end
        end

        // A write requested during active video waits for vertical blanking.
        a = 16'($urandom_range(0, FB_BYTES - 1)); d = 8'($urandom);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        vis_acks = 0;
        jump(100, 0);
        repeat (800) begin
            tick();
            if (wr_ack || sram_we) vis_acks++;
            adv(1'b0);
        end
        jump(479, 780);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            pv = int'(vcnt);
            tick();
            if (wr_ack) begin
                got = 1'b1;
                chk("ack_in_blank", 32'(pv >= 480), 1);
                chk("blank_we", 32'(sram_we), 1);
                chk("blank_addr", 32'(sram_addr), 32'(a));
                chk("blank_wdata", 32'(sram_wdata), 32'(d));
                exp_fb[a] = d;
            end
            adv(1'b0);
        end
        if (!got) chk("blank_ack_timeout", 0, 1);
        chk("visible_acks", 32'(vis_acks), 0);

        // Random blanking writes, some out of range, some back-to-back.
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(FB_BYTES, 65535))
                                            : 16'($urandom_range(0, FB_BYTES - 1));
            d = 8'($urandom);
            wr_req = 1'b1; wr_addr = a; wr_data = d;
            got = 1'b0;
            for (int c = 0; c < 64 && !got; c++) begin
                tick();
                if (wr_ack) begin
                    got = 1'b1;
                    chk("rnd_we", 32'(sram_we), 32'(int'(a) < FB_BYTES));
                    if (int'(a) < FB_BYTES) begin
                        chk("rnd_addr", 32'(sram_addr), 32'(a));
                        chk("rnd_wdata", 32'(sram_wdata), 32'(d));
                        exp_fb[a] = d;
                    end
                end
                adv(1'b0);
            end
            if (!got) chk("rnd_ack_timeout", 0, 1);
            if ($urandom_range(0, 1) == 1) begin
                wr_req = 1'b0;
                tick();
                chk("idle_we", 32'(sram_we), 0);
                chk("idle_ack", 32'(wr_ack), 0);
                adv(1'b0);
            end
        end
        wr_req = 1'b0;

        // Clear interrupted by reset after 1000 writes; reset also swallows fresh requests.
        jump(480, 0);
        clr_req = 1'b1;
        tick();
        chk("clrd_busy_rise", 32'(clr_busy), 1);
        chk("clrd_first_we", 32'(sram_we), 0);
        clr_req = 1'b0;
        adv(1'b0);
        nwr = 0; seq_err = 0;
        for (int c = 0; c < 2000 && nwr < 1000; c++) begin
            tick();
            if (sram_we) begin
                if (int'(sram_addr) != nwr || sram_wdata != 8'h00) seq_err++;
                nwr++;
            end
            adv(1'b0);
        end
        chk("clrd_count", 32'(nwr), 1000);
        chk("clrd_seq", 32'(seq_err), 0);
        for (int i = 0; i < 1000; i++) exp_fb[i] = 8'h00;
        reset = 1'b1; clr_req = 1'b1; wr_req = 1'b1; wr_addr = 16'd500; wr_data = 8'h77;
        tick();
        chk("rstclr_busy", 32'(clr_busy), 0);
        chk("rstclr_we", 32'(sram_we), 0);
        chk("rstclr_ack", 32'(wr_ack), 0);
        reset = 1'b0; clr_req = 1'b0; wr_req = 1'b0;
        adv(1'b0);
        stray = 0;
        repeat (200) begin
            tick();
            if (sram_we || clr_busy) stray++;
            adv(1'b0);
        end
        chk("rstclr_stray", 32'(stray), 0);
        fb_compare("fb_after_partial");

        // Full clear with a concurrent write request and a redundant clr_req mid-way.
        jump(480, 0);
        clr_req = 1'b1; wr_req = 1'b1; wr_addr = 16'd2000; wr_data = 8'h99;
        tick();
        chk("clr_busy_rise", 32'(clr_busy), 1);
        chk("clr_start_ack", 32'(wr_ack), 0);
        chk("clr_start_we", 32'(sram_we), 0);
        clr_req = 1'b0;
        adv(1'b1);
        nwr = 0; seq_err = 0; done = 1'b0; repulsed = 1'b0; prev_busy = 1'b1;
        for (int c = 0; c < 42000 && !done; c++) begin
            clr_req = (nwr == 20000) && !repulsed;
            if (clr_req) repulsed = 1'b1;
            tick();
            if (wr_ack) begin
                done = 1'b1;
                chk("post_clr_ack_order", 32'(nwr), 32'(FB_BYTES));
                chk("post_clr_we", 32'(sram_we), 1);
                chk("post_clr_addr", 32'(sram_addr), 2000);
                chk("post_clr_wdata", 32'(sram_wdata), 32'h99);
                exp_fb[2000] = 8'h99;
            end else if (sram_we) begin
                if (int'(sram_addr) != nwr || sram_wdata != 8'h00) seq_err++;
                nwr++;
            end
            if (prev_busy && !clr_busy) chk("clr_done_count", 32'(nwr), 32'(FB_BYTES));
            prev_busy = clr_busy;
            adv(1'b1);
        end
        clr_req = 1'b0; wr_req = 1'b0;
        if (!done) chk("clr_timeout", 0, 1);
        chk("clr_seq", 32'(seq_err), 0);
        for (int i = 0; i < FB_BYTES; i++) exp_fb[i] = (i == 2000) ? 8'h99 : 8'h00;
        tick();
        fb_compare("fb_after_clear");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
